// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the fetch path
package mips_pkg;
    localparam int          WORD_W   = 32;
    localparam logic [31:0] NOP_INSN = 32'h00000000;
    localparam logic [31:0] PC_STEP  = 32'd4;
endpackage

// File: rtl/fq_mem.sv
// fq_mem: DEPTH x 64-bit entry storage, one write port, combinational read, no reset
module fq_mem #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic            clk,
    input  logic            we,
    input  logic [PTRW-1:0] waddr,
    input  logic [63:0]     wdata,
    input  logic [PTRW-1:0] raddr,
    output logic [63:0]     rdata
);
    logic [63:0] mem [DEPTH];
    // write the pushed {pc, ir} pair at the tail slot
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction queue between fetch and decode with flush and 1-cycle latency
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_pc,
    input  logic [WORD_W-1:0] in_ir,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_pc,
    output logic [WORD_W-1:0] out_pc4,
    output logic [WORD_W-1:0] out_ir,
    input  logic              out_ready,
    output logic [PTRW:0]     count
);
    logic [PTRW-1:0] head, tail;
    logic [63:0]     rdata;
    logic            push, pop;

    // readiness depends only on state so a full queue never chains through a same-cycle pop
    assign in_ready  = count != (PTRW+1)'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    // an empty queue presents a NOP at PC 0 rather than stale storage
    assign out_pc    = out_valid ? rdata[63:32] : '0;
    assign out_ir    = out_valid ? rdata[31:0] : NOP_INSN;
    assign out_pc4   = out_pc + PC_STEP;

    fq_mem #(.DEPTH(DEPTH), .PTRW(PTRW)) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(tail),
        .wdata({in_pc, in_ir}),
        .raddr(head),
        .rdata(rdata)
    );

    // pointers wrap naturally at the power-of-two depth; flush clears all validity state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + (PTRW+1)'(push) - (PTRW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed check of fetch_queue against a queue model
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int PTRW  = 2;

    logic        clk = 0;
    logic        reset = 1;
    logic        in_valid = 0, flush = 0, out_ready = 0;
    logic [31:0] in_pc = 0, in_ir = 0;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_pc4, out_ir;
    logic [PTRW:0] count;

    int errors = 0;
    int checks = 0;
    logic [63:0] q[$];

    fetch_queue #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_ir(in_ir),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
        .out_pc4(out_pc4), .out_ir(out_ir), .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: a plain queue of {pc, ir}, updated from the pre-edge fullness
    always @(posedge clk or posedge reset) begin
        if (reset) q.delete();
        else if (flush) q.delete();
        else begin
            bit do_push, do_pop;
            do_push = in_valid && q.size() < DEPTH;
            do_pop  = out_ready && q.size() != 0;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({in_pc, in_ir});
        end
    end

    // every cycle: DUT outputs must match the model head and occupancy
    always @(negedge clk) begin
        logic [31:0] epc, eir;
        epc = q.size() != 0 ? q[0][63:32] : 32'h0;
        eir = q.size() != 0 ? q[0][31:0] : 32'h0;
        chk("m_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        chk("m_ready", {31'b0, in_ready}, {31'b0, q.size() != DEPTH});
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_pc", out_pc, epc);
        chk("m_ir", out_ir, eir);
        chk("m_pc4", out_pc4, epc + 32'd4);
    end

    // drive inputs just after a falling edge; return just after the next falling edge
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                         input logic f, input logic r);
        in_valid = v; in_pc = pc; in_ir = ir; flush = f; out_ready = r;
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_pc4", out_pc4, 32'd4);
        chk("rst_ir", out_ir, 32'd0);
        reset = 0;

        drive(1, 32'h34, 32'h20080005, 0, 0);
        chk("one_valid", {31'b0, out_valid}, 32'd1);
        chk("one_pc", out_pc, 32'h34);
        chk("one_pc4", out_pc4, 32'h38);
        chk("one_ir", out_ir, 32'h20080005);
        chk("one_count", 32'(count), 32'd1);
        drive(0, 0, 0, 0, 1);
        chk("one_drain", 32'(count), 32'd0);

        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h34 + 32'(4 * i), 32'h1000 + 32'(i), 0, 0);
            if (i >= 3) begin
                chk("full_ready", {31'b0, in_ready}, 32'd0);
                chk("full_count", 32'(count), 32'd4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", out_pc, 32'h34 + 32'(4 * i));
            chk("drain_ir", out_ir, 32'h1000 + 32'(i));
            drive(0, 0, 0, 0, 1);
        end
        chk("drain_empty", 32'(count), 32'd0);

        drive(1, 32'h100, 32'hA0, 0, 0);
        drive(1, 32'h104, 32'hA1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            chk("pp_pc", out_pc, 32'h100 + 32'(4 * i));
            drive(1, 32'h108 + 32'(4 * i), 32'hA2 + 32'(i), 0, 1);
            chk("pp_count", 32'(count), 32'd2);
        end
        drive(1, 32'h200, 32'hB0, 0, 0);
        chk("pre_flush", 32'(count), 32'd3);
        drive(1, 32'h500, 32'hC0, 1, 1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        drive(0, 0, 0, 0, 0);
        chk("flush_hidden", {31'b0, out_valid}, 32'd0);

        for (int i = 0; i < 3; i++) drive(1, 32'h300 + 32'(4 * i), 32'hD0, 0, 0);
        chk("pre_reset", 32'(count), 32'd3);
        in_valid = 0;
        #2;
        reset = 1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_ir", out_ir, 32'd0);
        chk("arst_pc4", out_pc4, 32'd4);
        @(negedge clk);
        #2;
        reset = 0;
        drive(1, 32'h600, 32'hE0, 0, 0);
        chk("post_rst_push", 32'(count), 32'd1);

        drive(0, 0, 0, 1, 0);
        drive(1, 32'hFFFFFFFC, 32'hF0, 0, 0);
        chk("wrap_pc", out_pc, 32'hFFFFFFFC);
        chk("wrap_pc4", out_pc4, 32'h0);

        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
